// File: rtl/crtc_row_fetch.sv
// crtc_row_fetch: DMA row-fetch and double-buffer engine for the CRT controller.
// A fetch FSM pulls one character row from the DMA controller into the fetch
// buffer in bursts separated by idle gaps. The other buffer feeds the display.
// row_adv swaps the two buffers.
//
// Parameters: MAX_COLS (row buffer depth), BURST (transfers per DRQ burst),
//             GAP (idle clocks between bursts).
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cfg_cols, cfg_rows    columns-1 / rows-1, both sampled at frame_start
//   frame_start, row_adv  frame and row strobes from the timing generator
//   drq / dack / ichar    DMA request, acknowledge and data
//   char_en / char_out    display strobe and registered display character
//   irq / irq_ack         sticky end-of-screen interrupt and its clear
//   underrun              sticky flag, set when a row was not fetched in time
//   underrun_cnt          underrun event counter
// Optional feature: define CRTC_FETCH_STATS_EN to build the underrun counter.
// Without it, underrun_cnt is tied to zero.
module crtc_row_fetch #(
  parameter int unsigned MAX_COLS = 80,
  parameter int unsigned BURST    = 1,
  parameter int unsigned GAP      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  cfg_cols,
  input  logic [5:0]  cfg_rows,
  input  logic        frame_start,
  input  logic        row_adv,
  output logic        drq,
  input  logic        dack,
  input  logic [7:0]  ichar,
  input  logic        char_en,
  output logic [7:0]  char_out,
  output logic        irq,
  input  logic        irq_ack,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned AW        = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [7:0]  MAXC      = 8'(MAX_COLS);
  localparam logic [7:0]  COL_LAST  = 8'(MAX_COLS - 1);
  localparam logic [3:0]  BEAT_LAST = 4'(BURST - 1);
  localparam logic [7:0]  GAP_LAST  = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam bit          HAS_GAP   = (GAP != 0);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_DONE, S_STOP} state_t;

  state_t      state, state_d;
  logic        sel;              // display buffer index; the fetch buffer is ~sel
  logic [7:0]  len [2];
  logic [7:0]  mem [2][MAX_COLS];
  logic [7:0]  wr_ptr, rd_ptr;
  logic [6:0]  row, row_nxt;
  logic [7:0]  cols_q;
  logic [5:0]  rows_q;
  logic [3:0]  beat_cnt;
  logic [7:0]  gap_cnt;

  logic xfer, eor, eos, swap, adv, in_flight, wr_en, irq_set, ur_set;
  logic       dsel, rd_hit;
  logic [7:0] dptr;

  always_comb begin
    state_d   = state;
    xfer      = drq & dack;
    eor       = (ichar == 8'hF1);
    eos       = (ichar == 8'hF3);
    swap      = row_adv & ~frame_start;
    in_flight = (state == S_FETCH) || (state == S_GAP);
    adv       = swap & (in_flight || (state == S_DONE));
    wr_en     = xfer & ~frame_start & ~eor & ~eos;
    ur_set    = adv & in_flight;
    row_nxt   = row + 7'd1;
    irq_set   = 1'b0;
    if (frame_start) begin
      state_d = S_FETCH;
    end else if (adv) begin
      state_d = (row_nxt <= {1'b0, rows_q}) ? S_FETCH : S_STOP;
      irq_set = (row == {1'b0, rows_q});
    end else begin
      case (state)
        S_FETCH: begin
          if (xfer) begin
            if (eos) begin
              state_d = S_STOP;
              irq_set = 1'b1;
            end else if (eor || (wr_ptr == cols_q)) begin
              state_d = S_DONE;
            end else if ((beat_cnt == BEAT_LAST) && HAS_GAP) begin
              state_d = S_GAP;
            end
          end
        end
        S_GAP:   if (gap_cnt == '0) state_d = S_FETCH;
        default: ;
      endcase
    end
    // char_en coinciding with a swap reads position 0 of the incoming buffer
    dsel   = swap ? ~sel : sel;
    dptr   = swap ? '0 : rd_ptr;
    rd_hit = (dptr < len[dsel]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      drq   <= 1'b0;
    end else begin
      state <= state_d;
      drq   <= (state_d == S_FETCH);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[~sel][wr_ptr[AW-1:0]] <= ichar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= 1'b0;
      len[0]   <= '0;
      len[1]   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      row      <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      char_out <= '0;
      irq      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (frame_start) begin
        wr_ptr    <= '0;
        len[~sel] <= '0;
        row       <= '0;
        cols_q    <= ({1'b0, cfg_cols} >= MAXC) ? COL_LAST : {1'b0, cfg_cols};
        rows_q    <= cfg_rows;
      end else begin
        if (wr_en) begin
          wr_ptr    <= wr_ptr + 8'd1;
          len[~sel] <= wr_ptr + 8'd1;
        end
        if (swap) begin
          sel      <= ~sel;
          wr_ptr   <= '0;
          len[sel] <= '0;
        end
        if (adv) row <= row_nxt;
      end

      if (frame_start || swap || (state_d != S_FETCH)) beat_cnt <= '0;
      else if (xfer) beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 4'd1;

      if ((state_d == S_GAP) && (state != S_GAP)) gap_cnt <= GAP_LAST;
      else if (state == S_GAP) gap_cnt <= gap_cnt - 8'd1;

      if (irq_set) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;

      if (frame_start) underrun <= 1'b0;
      else if (ur_set) underrun <= 1'b1;

      if (char_en) begin
        char_out <= rd_hit ? mem[dsel][dptr[AW-1:0]] : 8'h00;
        rd_ptr   <= (dptr == MAXC) ? dptr : dptr + 8'd1;
      end else if (swap) begin
        rd_ptr <= '0;
      end
    end
  end

`ifdef CRTC_FETCH_STATS_EN
  logic [15:0] ur_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ur_cnt <= '0;
    else if (ur_set) ur_cnt <= ur_cnt + 16'd1;
  end
  assign underrun_cnt = ur_cnt;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_crtc_row_fetch.sv
// Self-checking bench for crtc_row_fetch (MAX_COLS=16, BURST=2, GAP=3).
// DMA data comes from a source array indexed by the running transfer count.
// Expected rows come from scanning that array with the row rules.
module tb_crtc_row_fetch;
  localparam int MAXC = 16;
  localparam int BRST = 2;
  localparam int GAPC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  cfg_cols;
  logic [5:0]  cfg_rows;
  logic        frame_start, row_adv, dack, char_en, irq_ack;
  logic [7:0]  ichar;
  logic        drq, irq, underrun;
  logic [7:0]  char_out;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int failures = 0;
  int n_xfer = 0;
  int xfer_base = 0;
  int ur_events = 0;
  logic [7:0] src [256];

  always #5 clk = ~clk;

  crtc_row_fetch #(.MAX_COLS(MAXC), .BURST(BRST), .GAP(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .frame_start(frame_start), .row_adv(row_adv), .drq(drq), .dack(dack),
    .ichar(ichar), .char_en(char_en), .char_out(char_out), .irq(irq),
    .irq_ack(irq_ack), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  assign ichar = src[n_xfer[7:0]];
  always @(posedge clk) if (drq && dack) n_xfer <= n_xfer + 1;

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom_range(1, 255));
    while (b == 8'hF1 || b == 8'hF3) b = 8'($urandom_range(1, 255));
    return b;
  endfunction

  function automatic int row_len(input int start, input int ncols);
    for (int i = 0; i < ncols; i++)
      if (src[8'(start + i)] == 8'hF1 || src[8'(start + i)] == 8'hF3) return i;
    return ncols;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef CRTC_FETCH_STATS_EN
    return 16'(ur_events);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic quiesce();
    @(negedge clk); dack = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_src();
    xfer_base = n_xfer;
    for (int i = 0; i < 96; i++) src[8'(xfer_base + i)] = rnd_byte();
  endtask

  task automatic start_frame(input logic [6:0] c, input logic [5:0] r, input logic d);
    @(negedge clk); dack = 1'b0; cfg_cols = c; cfg_rows = r; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0; dack = d;
  endtask

  task automatic pulse_row_adv(input logic ack);
    @(negedge clk); row_adv = 1'b1; irq_ack = ack;
    @(negedge clk); row_adv = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic ack_irq();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input bit rnd, input string tag);
    int c = 0;
    while ((n_xfer - xfer_base) < target && c < 2000) begin
      @(negedge clk);
      if (rnd) dack = 1'($urandom_range(0, 1));
      c++;
    end
    checks++;
    if (c >= 2000) begin
      failures++;
      $display("FAIL %s_timeout got=%0d transfers required=%0d", tag, n_xfer - xfer_base, target);
    end
  endtask

  task automatic read_row(input int start, input int nstored, input int npos, input string tag);
    logic [7:0] exp = 8'h00;
    @(negedge clk); row_adv = 1'b1; char_en = 1'b1;
    for (int i = 0; i < npos; i++) begin
      @(negedge clk);
      row_adv = 1'b0;
      if (i == npos - 1) char_en = 1'b0;
      exp = (i < nstored) ? src[8'(start + i)] : 8'h00;
      checks++;
      if (char_out !== exp) begin
        failures++;
        $display("FAIL %s[%0d] got=%h required=%h", tag, i, char_out, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (char_out !== exp) begin
      failures++;
      $display("FAIL %s_hold got=%h required=%h", tag, char_out, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_cols = '0; cfg_rows = '0; frame_start = 1'b0; row_adv = 1'b0;
    dack = 1'b0; char_en = 1'b0; irq_ack = 1'b0;
    for (int i = 0; i < 256; i++) src[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (drq !== 1'b0) begin failures++; $display("FAIL reset_drq got=%b required=0", drq); end
    checks++; if (char_out !== 8'h00) begin failures++; $display("FAIL reset_char got=%h required=00", char_out); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b required=0", irq); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b required=0", underrun); end
    checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h required=0000", underrun_cnt); end
    rst_n = 1'b1;
    read_row(0, 0, 3, "idle_char");
    checks++; if (drq !== 1'b0) begin failures++; $display("FAIL idle_drq got=%b required=0", drq); end
  endtask

  task automatic test_basic();
    logic pat[$];
    logic exp_pat[$];
    int c = 0;
    int bad = -1;
    quiesce(); fill_src();
    for (int b = 0; b < 10 / BRST; b++) begin
      for (int k = 0; k < BRST; k++) exp_pat.push_back(1'b1);
      if (b < 10 / BRST - 1) for (int k = 0; k < GAPC; k++) exp_pat.push_back(1'b0);
    end
    exp_pat.push_back(1'b0);
    start_frame(7'd9, 6'd5, 1'b1);
    forever begin
      pat.push_back(drq);
      if ((n_xfer - xfer_base) >= 10 || c >= 200) break;
      @(negedge clk); c++;
    end
    checks++;
    if (c >= 200) begin failures++; $display("FAIL basic_timeout got=%0d transfers required=10", n_xfer - xfer_base); end
    for (int i = 0; i < exp_pat.size(); i++)
      if (bad < 0 && (i >= pat.size() || pat[i] !== exp_pat[i])) bad = i;
    checks++;
    if (bad >= 0 || pat.size() != exp_pat.size()) begin
      failures++;
      $display("FAIL basic_drq_pattern got_len=%0d required_len=%0d first_diff=%0d", pat.size(), exp_pat.size(), bad);
    end
    repeat (8) @(negedge clk);
    checks++; if (n_xfer - xfer_base != 10) begin failures++; $display("FAIL basic_xfers got=%0d required=10", n_xfer - xfer_base); end
    checks++; if (drq !== 1'b0) begin failures++; $display("FAIL basic_done_drq got=%b required=0", drq); end
    read_row(xfer_base, 10, 11, "basic_char");
  endtask

  task automatic test_end_of_row();
    logic seen = 1'b0;
    quiesce(); fill_src();
    src[8'(xfer_base + 3)] = 8'hF1;
    start_frame(7'd9, 6'd5, 1'b1);
    wait_xfers(4, 1'b0, "eor");
    for (int i = 0; i < 12; i++) begin seen |= drq; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL eor_drq got=%b required=0", seen); end
    checks++; if (n_xfer - xfer_base != 4) begin failures++; $display("FAIL eor_xfers got=%0d required=4", n_xfer - xfer_base); end
    read_row(xfer_base, 3, 10, "eor_char");
  endtask

  task automatic test_end_of_screen();
    logic seen = 1'b0;
    quiesce(); ack_irq();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL eos_pre_irq got=%b required=0", irq); end
    fill_src();
    src[8'(xfer_base + 10)] = 8'hF3;
    start_frame(7'd3, 6'd5, 1'b1);
    wait_xfers(4, 1'b0, "eos_row0");
    pulse_row_adv(1'b0);
    wait_xfers(8, 1'b0, "eos_row1");
    pulse_row_adv(1'b0);
    wait_xfers(10, 1'b0, "eos_row2");
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL eos_early_irq got=%b required=0", irq); end
    wait_xfers(11, 1'b0, "eos_code");
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL eos_irq got=%b required=1", irq); end
    for (int i = 0; i < 24; i++) begin
      seen |= drq;
      @(negedge clk);
      row_adv = (i == 3 || i == 12);
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL eos_stop_drq got=%b required=0", seen); end
    start_frame(7'd3, 6'd5, 1'b0);
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL eos_resume_drq got=%b required=1", drq); end
  endtask

  task automatic test_underrun();
    quiesce(); fill_src();
    start_frame(7'd9, 6'd5, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL ur_drq got=%b required=1", drq); end
    ur_events++;
    read_row(xfer_base, 0, 10, "ur_char");
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL ur_flag got=%b required=1", underrun); end
    checks++; if (underrun_cnt !== exp_cnt()) begin failures++; $display("FAIL ur_cnt got=%h required=%h", underrun_cnt, exp_cnt()); end
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL ur_refetch got=%b required=1", drq); end
    start_frame(7'd9, 6'd5, 1'b0);
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL ur_clear got=%b required=0", underrun); end
    checks++; if (underrun_cnt !== exp_cnt()) begin failures++; $display("FAIL ur_cnt_keep got=%h required=%h", underrun_cnt, exp_cnt()); end
  endtask

  task automatic test_last_row();
    logic seen = 1'b0;
    quiesce(); ack_irq(); fill_src();
    start_frame(7'd3, 6'd1, 1'b1);
    wait_xfers(4, 1'b0, "last_row0");
    pulse_row_adv(1'b0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL last_irq_row0 got=%b required=0", irq); end
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL last_drq_row1 got=%b required=1", drq); end
    wait_xfers(8, 1'b0, "last_row1");
    pulse_row_adv(1'b0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL last_irq got=%b required=1", irq); end
    for (int i = 0; i < 6; i++) begin seen |= drq; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL last_stop_drq got=%b required=0", seen); end
    ack_irq();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL last_ack got=%b required=0", irq); end
    quiesce(); fill_src();
    start_frame(7'd3, 6'd0, 1'b1);
    wait_xfers(4, 1'b0, "last_single");
    pulse_row_adv(1'b1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL last_set_over_ack got=%b required=1", irq); end
    ack_irq();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL last_ack2 got=%b required=0", irq); end
  endtask

  task automatic test_random_rows();
    for (int it = 0; it < 6; it++) begin
      int c, ncols, tp, stored, exp_x;
      quiesce(); fill_src();
      c = $urandom_range(0, 20);
      ncols = ((c > MAXC - 1) ? MAXC - 1 : c) + 1;
      tp = $urandom_range(0, 24);
      src[8'(xfer_base + tp)] = 8'hF1;
      stored = row_len(xfer_base, ncols);
      exp_x = (stored < ncols) ? stored + 1 : ncols;
      start_frame(7'(c), 6'd10, 1'b1);
      wait_xfers(exp_x, 1'b1, "rand");
      dack = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (n_xfer - xfer_base != exp_x) begin
        failures++;
        $display("FAIL rand_xfers cols=%0d got=%0d required=%0d", c, n_xfer - xfer_base, exp_x);
      end
      checks++; if (drq !== 1'b0) begin failures++; $display("FAIL rand_done_drq got=%b required=0", drq); end
      read_row(xfer_base, stored, MAXC + 2, "rand_char");
    end
  endtask

  task automatic test_reset_midburst();
    logic bad = 1'b0;
    quiesce(); fill_src();
    start_frame(7'd9, 6'd5, 1'b0);
    repeat (3) @(negedge clk);
    pulse_row_adv(1'b0);
    ur_events++;
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL rst_pre_underrun got=%b required=1", underrun); end
    dack = 1'b1;
    wait_xfers(1, 1'b0, "rst_burst");
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL rst_pre_drq got=%b required=1", drq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (drq !== 1'b0) begin failures++; $display("FAIL rst_async_drq got=%b required=0", drq); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b required=0", underrun); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b required=0", irq); end
    checks++; if (char_out !== 8'h00) begin failures++; $display("FAIL rst_char got=%h required=00", char_out); end
    checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h required=0000", underrun_cnt); end
    ur_events = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bad |= drq | irq | underrun | (char_out != 8'h00) | (underrun_cnt != 16'h0);
      row_adv = (i % 4 == 1);
      char_en = 1'($urandom_range(0, 1));
    end
    row_adv = 1'b0; char_en = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b required=0", bad); end
    start_frame(7'd9, 6'd5, 1'b1);
    checks++; if (drq !== 1'b1) begin failures++; $display("FAIL rst_restart_drq got=%b required=1", drq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_end_of_row();
    test_end_of_screen();
    test_underrun();
    test_last_row();
    test_random_rows();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
